// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a synchronous instruction ROM and feeds decode.
// Absorbs downstream stalls with a one-entry hold buffer and squashes wrong-path words on redirect.
module instr_fetch_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = 16'b00101_000_00000000
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_rd_en,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic [INSTR_WIDTH-1:0] instruction_output,
  output logic [PC_WIDTH-1:0]    pc_output,
  output logic                   fetch_valid
);

  typedef enum logic {ST_RUN, ST_STALL} state_t;

  state_t                 state;
  logic [PC_WIDTH-1:0]    pc;
  logic                   inflight;
  logic [PC_WIDTH-1:0]    inflight_pc;
  logic                   hold_valid;
  logic [INSTR_WIDTH-1:0] hold_instr;
  logic [PC_WIDTH-1:0]    hold_pc;

  // Handshake: a word issued on imem_addr while imem_rd_en=1 returns on imem_rdata one cycle later;
  // decode consumes instruction_output on every rising edge where stall=0.
  assign imem_rd_en = !rst && !stall;
  assign imem_addr  = redirect_valid ? redirect_pc : pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= ST_RUN;
      pc                 <= RESET_PC;
      inflight           <= 1'b0;
      inflight_pc        <= '0;
      hold_valid         <= 1'b0;
      hold_instr         <= NOP_INSTR;
      hold_pc            <= '0;
      instruction_output <= NOP_INSTR;
      pc_output          <= '0;
      fetch_valid        <= 1'b0;
    end else if (redirect_valid) begin
      // The in-flight word and any held word belong to the wrong path: drop both.
      hold_valid <= 1'b0;
      if (stall) begin
        state    <= ST_STALL;
        pc       <= redirect_pc;
        inflight <= 1'b0;
      end else begin
        state              <= ST_RUN;
        pc                 <= redirect_pc + 1'b1;
        inflight           <= 1'b1;
        inflight_pc        <= redirect_pc;
        instruction_output <= NOP_INSTR;
        fetch_valid        <= 1'b0;
      end
    end else if (stall) begin
      state    <= ST_STALL;
      inflight <= 1'b0;
      // Only the first stalled cycle can see a returning word, since nothing issues while stalled.
      if (state == ST_RUN && inflight) begin
        hold_instr <= imem_rdata;
        hold_pc    <= inflight_pc;
        hold_valid <= 1'b1;
      end
    end else begin
      state       <= ST_RUN;
      pc          <= pc + 1'b1;
      inflight    <= 1'b1;
      inflight_pc <= pc;
      if (hold_valid) begin
        instruction_output <= hold_instr;
        pc_output          <= hold_pc;
        fetch_valid        <= 1'b1;
        hold_valid         <= 1'b0;
      end else if (inflight) begin
        instruction_output <= imem_rdata;
        pc_output          <= inflight_pc;
        fetch_valid        <= 1'b1;
      end else begin
        instruction_output <= NOP_INSTR;
        fetch_valid        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a synchronous ROM holding 16'h1000+n, a vector table
// covering streaming, stall, redirect, redirect-under-stall and PC wrap, then an async reset sequence.
module tb_instr_fetch_unit;

  localparam logic [15:0] NOP = 16'b00101_000_00000000;

  logic        clk;
  logic        rst;
  logic        imem_rd_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [15:0] instruction_output;
  logic [7:0]  pc_output;
  logic        fetch_valid;

  int checks;
  int errors;

  instr_fetch_unit dut (
    .clk                (clk),
    .rst                (rst),
    .imem_rd_en         (imem_rd_en),
    .imem_addr          (imem_addr),
    .imem_rdata         (imem_rdata),
    .stall              (stall),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .instruction_output (instruction_output),
    .pc_output          (pc_output),
    .fetch_valid        (fetch_valid)
  );

  // clock / reset / ROM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] rom [256];
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
    imem_rdata = '0;
  end
  always @(posedge clk) if (imem_rd_en) imem_rdata <= rom[imem_addr];

  // scoreboard helpers
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        rv;
    logic [7:0]  rpc;
    logic [7:0]  exp_addr;
    logic        exp_valid;
    logic [15:0] exp_instr;
    logic [7:0]  exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic rv, input logic [7:0] rpc, input logic [7:0] ea,
                     input logic ev, input logic [15:0] ei, input logic [7:0] ep);
    vec_t v;
    v.stall = s; v.rv = rv; v.rpc = rpc; v.exp_addr = ea;
    v.exp_valid = ev; v.exp_instr = ei; v.exp_pc = ep;
    vecs.push_back(v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    //   stall rv  rpc    addr   valid instr     pc
    add(0, 0, 8'h00, 8'h00, 0, NOP,      8'h00);  // first issue, bubble
    add(0, 0, 8'h00, 8'h01, 1, 16'h1000, 8'h00);  // first word on cycle 2
    add(0, 0, 8'h00, 8'h02, 1, 16'h1001, 8'h01);
    add(0, 0, 8'h00, 8'h03, 1, 16'h1002, 8'h02);
    add(0, 0, 8'h00, 8'h04, 1, 16'h1003, 8'h03);
    add(0, 0, 8'h00, 8'h05, 1, 16'h1004, 8'h04);  // ROM[5] now in flight
    add(1, 0, 8'h00, 8'h06, 1, 16'h1004, 8'h04);  // stall x3, output frozen
    add(1, 0, 8'h00, 8'h06, 1, 16'h1004, 8'h04);
    add(1, 0, 8'h00, 8'h06, 1, 16'h1004, 8'h04);
    add(0, 0, 8'h00, 8'h06, 1, 16'h1005, 8'h05);  // held word drains
    add(0, 0, 8'h00, 8'h07, 1, 16'h1006, 8'h06);  // back-to-back, ROM[7] in flight
    add(0, 1, 8'h40, 8'h40, 0, NOP,      8'h00);  // redirect bubble, ROM[7] squashed
    add(0, 0, 8'h00, 8'h41, 1, 16'h1040, 8'h40);
    add(0, 0, 8'h00, 8'h42, 1, 16'h1041, 8'h41);
    add(1, 1, 8'h80, 8'h80, 1, 16'h1041, 8'h41);  // redirect under stall: frozen
    add(1, 0, 8'h00, 8'h80, 1, 16'h1041, 8'h41);
    add(0, 0, 8'h00, 8'h80, 0, NOP,      8'h00);  // release: target issued
    add(0, 0, 8'h00, 8'h81, 1, 16'h1080, 8'h80);
    add(0, 1, 8'hFE, 8'hFE, 0, NOP,      8'h00);  // redirect near wrap
    add(0, 0, 8'h00, 8'hFF, 1, 16'h10FE, 8'hFE);
    add(0, 0, 8'h00, 8'h00, 1, 16'h10FF, 8'hFF);
    add(0, 0, 8'h00, 8'h01, 1, 16'h1000, 8'h00);
    add(0, 0, 8'h00, 8'h02, 1, 16'h1001, 8'h01);
    add(1, 0, 8'h00, 8'h03, 1, 16'h1001, 8'h01);  // stall fills hold with ROM[2]
    add(0, 1, 8'h10, 8'h10, 0, NOP,      8'h00);  // redirect beats hold drain
    add(0, 0, 8'h00, 8'h11, 1, 16'h1010, 8'h10);
    add(0, 0, 8'h00, 8'h12, 1, 16'h1011, 8'h11);

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_instr", instruction_output, NOP);
    check("reset_pc", 16'(pc_output), 16'h0000);
    check("reset_valid", 16'(fetch_valid), 16'h0000);
    check("reset_rd_en", 16'(imem_rd_en), 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      stall = vecs[i].stall;
      redirect_valid = vecs[i].rv;
      redirect_pc = vecs[i].rpc;
      #1;
      check($sformatf("v%0d_addr", i), 16'(imem_addr), 16'(vecs[i].exp_addr));
      check($sformatf("v%0d_rd_en", i), 16'(imem_rd_en), 16'(!vecs[i].stall));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), 16'(fetch_valid), 16'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_instr", i), instruction_output, vecs[i].exp_instr);
        check($sformatf("v%0d_pc", i), 16'(pc_output), 16'(vecs[i].exp_pc));
      end else begin
        check($sformatf("v%0d_nop", i), instruction_output, NOP);
      end
      @(negedge clk);
    end
    stall = 1'b0;
    redirect_valid = 1'b0;

    // async reset while stalled with a held word
    stall = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_instr", instruction_output, NOP);
    check("async_rst_pc", 16'(pc_output), 16'h0000);
    check("async_rst_valid", 16'(fetch_valid), 16'h0000);
    check("async_rst_rd_en", 16'(imem_rd_en), 16'h0000);
    @(negedge clk);
    stall = 1'b0;
    rst = 1'b0;
    begin
      int cycles;
      cycles = 0;
      while (!fetch_valid && cycles < 10) begin
        @(posedge clk);
        #1;
        cycles++;
      end
      check("restart_latency", 16'(cycles), 16'd2);
      check("restart_instr", instruction_output, 16'h1000);
      check("restart_pc", 16'(pc_output), 16'h0000);
      @(posedge clk);
      #1;
      check("restart_next_instr", instruction_output, 16'h1001);
      check("restart_next_pc", 16'(pc_output), 16'h0001);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
